// File: rtl/kuznechik_pkg.sv
// Shared types and constants for the Kuznechik decryption sequencer.
// Block width, FSM state encoding and chaining-mode selectors.
package kuznechik_pkg;

  localparam int BLOCK_W = 128;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_RUN,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/kuznechik_cbc_decrypt_ctrl_if.sv
// Host-side block streams of the decryption sequencer.
// master = host/testbench side, slave = sequencer side.
interface kuznechik_cbc_decrypt_ctrl_if;
  import kuznechik_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_data;
  logic   in_last;
  logic   out_valid;
  logic   out_ready;
  block_t out_data;
  logic   out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/kuznechik_out_buf.sv
// One-entry output register slice for plaintext blocks.
// Loaded only while empty, so load and drain never collide.
module kuznechik_out_buf
  import kuznechik_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  block_t data_i,
  input  logic   last_i,
  input  logic   ready_i,
  output logic   valid_o,
  output block_t data_o,
  output logic   last_o
);

  logic   valid_q;
  block_t data_q;
  logic   last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/kuznechik_cbc_decrypt_ctrl.sv
// Feeds ciphertext blocks through one Kuznechik decryption core,
// applying ECB or CBC chaining and owning the core enable/finish handshake.
module kuznechik_cbc_decrypt_ctrl
  import kuznechik_pkg::*;
#(
  parameter int DRAIN_CYCLES = 256
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   mode,
  input  logic   keys_valid,
  input  logic   iv_load,
  input  block_t iv_in,
  kuznechik_cbc_decrypt_ctrl_if.slave io,
  output logic   core_enable,
  output block_t core_word,
  input  block_t core_result,
  input  logic   core_finish,
  output logic   busy
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  block_t        iv_q;
  block_t        chain_q;
  block_t        cipher_q;
  logic          last_q;
  logic          mode_q;
  logic          en_q;

  logic   accept;
  logic   out_load;
  block_t plain;

  assign io.in_ready = (state_q == ST_IDLE) && keys_valid;
  assign accept      = io.in_valid && io.in_ready;
  assign out_load    = (state_q == ST_RUN) && core_finish && !io.out_valid;
  assign plain       = core_result ^ ((mode_q == MODE_CBC) ? chain_q : '0);

  // DRAIN lets a core abandoned by reset finish before we ever enable it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DRAIN;
      cnt_q    <= CW'(DRAIN_CYCLES - 1);
      iv_q     <= '0;
      chain_q  <= '0;
      cipher_q <= '0;
      last_q   <= 1'b0;
      mode_q   <= MODE_ECB;
      en_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_DRAIN: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        ST_IDLE: begin
          if (iv_load) begin
            iv_q    <= iv_in;
            chain_q <= iv_in;
          end
          if (accept) begin
            cipher_q <= io.in_data;
            last_q   <= io.in_last;
            mode_q   <= mode;
            en_q     <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_load) begin
            en_q    <= 1'b0;
            state_q <= ST_RELEASE;
            if (mode_q == MODE_CBC)
              chain_q <= last_q ? iv_q : cipher_q;
          end
        end
        ST_RELEASE: begin
          if (!core_finish) state_q <= ST_IDLE;
        end
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  kuznechik_out_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .data_i  (plain),
    .last_i  (last_q),
    .ready_i (io.out_ready),
    .valid_o (io.out_valid),
    .data_o  (io.out_data),
    .last_o  (io.out_last)
  );

  assign core_enable = en_q;
  assign core_word   = cipher_q;
  assign busy        = (state_q != ST_IDLE) || io.out_valid;

endmodule

// File: tb/tb_kuznechik_cbc_decrypt_ctrl.sv
// Self-checking bench: behavioural core stand-in plus an ECB/CBC
// reference model of the expected plaintext stream.
module tb_kuznechik_cbc_decrypt_ctrl;

  localparam int DRAIN = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic         keys_valid = 1'b1;
  logic         iv_load = 1'b0;
  logic [127:0] iv_in = '0;
  logic         core_enable;
  logic [127:0] core_word;
  logic [127:0] core_result = '0;
  logic         core_finish = 1'b0;
  logic         busy;

  kuznechik_cbc_decrypt_ctrl_if bus ();

  kuznechik_cbc_decrypt_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .keys_valid  (keys_valid),
    .iv_load     (iv_load),
    .iv_in       (iv_in),
    .io          (bus),
    .core_enable (core_enable),
    .core_word   (core_word),
    .core_result (core_result),
    .core_finish (core_finish),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Core stand-in: GOST known answer for the standard vector, a fixed
  // rotate/xor permutation otherwise.
  function automatic logic [127:0] core_d(input logic [127:0] c);
    if (c == 128'h7f679d90bebc24305a468d42b9d4edcd)
      return 128'h1122334455667700ffeeddccbbaa9988;
    return {c[60:0], c[127:61]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  int   lat = 6;
  int   ccnt = 0;
  logic drop = 1'b0;

  // Finish holds while enabled; drops two cycles after enable falls.
  always @(posedge clk) begin
    if (core_enable) begin
      drop <= 1'b0;
      if (!core_finish) begin
        if (ccnt >= lat) begin
          core_finish <= 1'b1;
          core_result <= core_d(core_word);
        end else begin
          ccnt <= ccnt + 1;
        end
      end
    end else begin
      ccnt <= 0;
      if (core_finish) begin
        if (drop) begin
          core_finish <= 1'b0;
          drop        <= 1'b0;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

  // Reference model: chain holds the previous ciphertext, reset to IV after a last block.
  logic [127:0] m_iv = '0;
  logic [127:0] m_chain = '0;
  logic [128:0] exp_q[$];
  logic [128:0] got_q[$];

  bit rnd_rdy = 1'b0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_last, bus.out_data});
  end

  task automatic send_block(input logic [127:0] c, input logic last,
                            input logic m, input logic ld,
                            input logic [127:0] ivv, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    bus.in_last  = last;
    mode         = m;
    iv_load      = ld;
    iv_in        = ivv;
    if (ld) begin
      m_iv    = ivv;
      m_chain = ivv;
    end
    if (m) begin
      exp_q.push_back({last, core_d(c) ^ m_chain});
      m_chain = last ? m_iv : c;
    end else begin
      exp_q.push_back({last, core_d(c)});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    iv_load      = 1'b0;
  endtask

  task automatic load_iv(input logic [127:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    iv_load = 1'b1;
    iv_in   = v;
    m_iv    = v;
    m_chain = v;
    @(negedge clk);
    iv_load = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (got_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  en_seen;
    #3;
    n_assert++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, core_enable, busy} !== 5'b00001 ||
        bus.out_data !== '0 || core_word !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b ov=%b ol=%b en=%b busy=%b od=%h cw=%h required 0 0 0 0 1 0 0",
               bus.in_ready, bus.out_valid, bus.out_last, core_enable, busy,
               bus.out_data, core_word);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    en_seen = 1'b0;
    while (!bus.in_ready && n < DRAIN + 50) begin
      if (core_enable) en_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    n_assert++;
    if (n != DRAIN) begin
      n_fail++;
      $display("FAIL drain_len: got %0d cycles required %0d", n, DRAIN);
    end
    n_assert++;
    if (en_seen) begin
      n_fail++;
      $display("FAIL drain_enable: core_enable got 1 required 0");
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_keys_gate();
    keys_valid = 1'b0;
    #1;
    n_assert++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL keys_gate: in_ready got %b required 0", bus.in_ready);
    end
    keys_valid = 1'b1;
    #1;
    n_assert++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL keys_open: in_ready got %b required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_ecb_vector();
    bit ok;
    logic [128:0] e, g;
    logic [127:0] c;
    c = 128'h7f679d90bebc24305a468d42b9d4edcd;
    lat = 6;
    send_block(c, 1'b1, 1'b0, 1'b0, '0, ok);
    n_assert++;
    if (!ok || core_enable !== 1'b1 || core_word !== c) begin
      n_fail++;
      $display("FAIL ecb_start: ok=%b en=%b word=%h required 1 1 %h", ok, core_enable, core_word, c);
    end
    for (int i = 0; i < 100 && !core_finish; i++) @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b1 || core_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_timing: ov=%b en=%b required 1 0", bus.out_valid, core_enable);
    end
    for (int k = 0; k < 3; k++) begin
      n_assert++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_early: cycle %0d in_ready got 1 required 0", k);
      end
      @(negedge clk);
    end
    n_assert++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_return: in_ready got %b required 1", bus.in_ready);
    end
    wait_out(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL ecb_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL ecb_out: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_cbc_chain();
    bit ok;
    logic [128:0] e, g;
    load_iv(128'h0123456789abcdef0123456789abcdef, ok);
    for (int i = 0; i < 4; i++) begin
      lat = 3 + i;
      send_block({$urandom, $urandom, $urandom, $urandom}, (i == 2), 1'b1, 1'b0, '0, ok);
    end
    wait_out(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL cbc_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL cbc_out: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held;
    logic [128:0] e, g;
    lat = 4;
    bus.out_ready = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0, '0, ok);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0, ok);
    for (int i = 0; i < 100 && !core_finish; i++) @(negedge clk);
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!core_enable || !core_finish || !bus.out_valid) held = 1'b0;
      @(negedge clk);
    end
    n_assert++;
    if (!held) begin
      n_fail++;
      $display("FAIL bp_hold: enable/finish/out_valid got dropped required held high");
    end
    bus.out_ready = 1'b1;
    wait_out(exp_q.size(), ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d outputs required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL bp_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL bp_out: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_iv_load();
    bit ok;
    logic [128:0] e, g;
    lat = 8;
    load_iv(128'hfeedface_0badf00d_12345678_9abcdef0, ok);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0, '0, ok);
    iv_load = 1'b1;
    iv_in   = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    repeat (2) @(negedge clk);
    iv_load = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0, ok);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1,
               128'h55aa55aa_00ff00ff_13572468_abcdef01, ok);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0, ok);
    wait_out(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL iv_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL iv_out: got %h required %h", g, e);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [128:0] e, g;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      lat = $urandom_range(1, 12);
      send_block({$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, '0, ok);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_out(exp_q.size(), ok);
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL rnd_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL rnd_out: got %h required %h", g, e);
        end
      end
    end
    n_assert++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_extra: got %0d surplus outputs required 0", got_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit ov_seen;
    int n;
    logic [128:0] e, g;
    lat = 30;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0, '0, ok);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_assert++;
    if (core_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_enable: core_enable got %b required 0", core_enable);
    end
    exp_q.delete();
    m_iv    = '0;
    m_chain = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    ov_seen = 1'b0;
    while (!bus.in_ready && n < DRAIN + 50) begin
      if (bus.out_valid || core_enable) ov_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    n_assert++;
    if (ov_seen || got_q.size() != 0 || n != DRAIN) begin
      n_fail++;
      $display("FAIL rst_drop: ov=%b outs=%0d drain=%0d required 0 0 %0d",
               ov_seen, got_q.size(), n, DRAIN);
    end
    lat = 5;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, '0, ok);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0, ok);
    wait_out(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL post_rst_out: missing, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL post_rst_out: got %h required %h", g, e);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_keys_gate();
    test_ecb_vector();
    test_cbc_chain();
    test_backpressure();
    test_iv_load();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
